// File: rtl/serv_irq_arb.sv
// rtl/serv_irq_arb.sv - edge-triggered interrupt arbiter with claim/complete bus registers
// Each source runs IDLE/PEND/ACT; the core claims the lowest enabled pending id and completes it by write.

module serv_irq_arb #(
  parameter int N = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_src,
  input  logic [1:0]    i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACT  = 2'd2
  } src_state_e;

  src_state_e   state_q [N];
  logic [N-1:0] repend_q;
  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] hist_q;
  logic [N-1:0] enable_q;
  logic         ack_q;
  logic         irq_q;
  logic [31:0]  rdt_q;

  logic [N-1:0] evt;
  logic [N-1:0] pend_vec;
  logic [N-1:0] act_vec;
  logic [N-1:0] claim_sel;
  logic [N-1:0] cmpl_sel;
  logic [4:0]   claim_id;
  logic [31:0]  rdt_d;
  logic         irq_d;
  logic         access;
  logic         claim_rd;
  logic         cmpl_wr;
  logic         enable_wr;
  logic         dat_unused;

  // An access executes only on the cycle its ack is being raised.
  assign access    = i_wb_cyc & ~ack_q;
  assign claim_rd  = access & ~i_wb_we & (i_wb_adr == 2'd2);
  assign cmpl_wr   = access &  i_wb_we & (i_wb_adr == 2'd2);
  assign enable_wr = access &  i_wb_we & (i_wb_adr == 2'd1);
  assign evt       = sync2_q & ~hist_q;
  assign dat_unused = &{1'b0, i_wb_dat};

  always_comb begin
    pend_vec = '0;
    act_vec  = '0;
    cmpl_sel = '0;
    for (int i = 0; i < N; i++) begin
      pend_vec[i] = (state_q[i] == PEND);
      act_vec[i]  = (state_q[i] == ACT);
      cmpl_sel[i] = cmpl_wr && (i_wb_dat[4:0] == 5'(i + 1)) && (state_q[i] == ACT);
    end
  end

  // Scan from the top so the lowest enabled pending index wins.
  always_comb begin
    claim_sel = '0;
    claim_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_vec[i] && enable_q[i]) begin
        claim_sel    = '0;
        claim_sel[i] = 1'b1;
        claim_id     = 5'(i + 1);
      end
    end
  end

  always_comb begin
    rdt_d = '0;
    case (i_wb_adr)
      2'd0:    rdt_d = 32'(pend_vec);
      2'd1:    rdt_d = 32'(enable_q);
      2'd2:    rdt_d = 32'(claim_id);
      default: rdt_d = 32'(act_vec);
    endcase
  end

  assign irq_d = (|(pend_vec & enable_q)) & ~(|act_vec);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) state_q[i] <= IDLE;
      repend_q <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      hist_q   <= '0;
      enable_q <= '0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdt_q    <= '0;
    end else begin
      sync1_q <= i_src;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      ack_q   <= i_wb_cyc & ~ack_q;
      rdt_q   <= (access && !i_wb_we) ? rdt_d : '0;
      irq_q   <= irq_d;
      if (enable_wr) enable_q <= i_wb_dat[N-1:0];
      for (int i = 0; i < N; i++) begin
        case (state_q[i])
          IDLE: if (evt[i]) state_q[i] <= PEND;
          PEND: begin
            if (claim_rd && claim_sel[i]) begin
              state_q[i]  <= ACT;
              repend_q[i] <= evt[i];
            end
          end
          ACT: begin
            if (cmpl_sel[i]) begin
              state_q[i]  <= (repend_q[i] || evt[i]) ? PEND : IDLE;
              repend_q[i] <= 1'b0;
            end else if (evt[i]) begin
              repend_q[i] <= 1'b1;
            end
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_serv_irq_arb.sv
// tb/tb_serv_irq_arb.sv - directed bench for serv_irq_arb
// Hand-computed expectations for each register access and o_irq sample.

module tb_serv_irq_arb;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] src;
  logic [1:0]   adr;
  logic [31:0]  dat;
  logic         we;
  logic         cyc;
  logic [31:0]  rdt;
  logic         ack;
  logic         irq;

  int n_checks = 0;
  int n_err    = 0;

  serv_irq_arb #(.N(N)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_src    (src),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_we  (we),
    .i_wb_cyc (cyc),
    .o_wb_rdt (rdt),
    .o_wb_ack (ack),
    .o_irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starts at a negedge; the access executes on the next rising edge.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] r, output logic k);
    cyc = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk); @(negedge clk);
    k = ack; r = rdt;
    cyc = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic k;
    bus(1'b0, a, 32'h0, r, k);
    check({tag, "_ack"}, 32'(k), 32'd1);
    check(tag, r, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic k;
    bus(1'b1, a, d, r, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; src = '0; adr = '0; dat = '0; we = 1'b0; cyc = 1'b0;
    wait_cyc(3);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdt", rdt, 32'd0);
    rst_n = 1'b1;
    wait_cyc(1);
    rd("rst_pending", 2'd0, 32'h0);
    rd("rst_enable", 2'd1, 32'h0);
    rd("rst_active", 2'd3, 32'h0);
    check("rdt_idle", rdt, 32'd0);

    // Single source, latency of the synchronizer and the irq register
    wr(2'd1, 32'h04);
    src[2] = 1'b1;
    wait_cyc(3);
    check("s2_irq_edge3", 32'(irq), 32'd0);
    wait_cyc(1);
    check("s2_irq_edge4", 32'(irq), 32'd1);
    rd("s2_pending", 2'd0, 32'h04);
    rd("s2_claim", 2'd2, 32'd3);
    check("s2_irq_drop", 32'(irq), 32'd0);
    rd("s2_active", 2'd3, 32'h04);
    rd("s2_pend_after", 2'd0, 32'h00);
    wr(2'd2, 32'd3);
    rd("s2_active_done", 2'd3, 32'h00);
    src[2] = 1'b0;

    // Two sources, lowest index wins
    wr(2'd1, 32'hFFFF_FFFF);
    rd("enable_mask", 2'd1, 32'hFF);
    src[5] = 1'b1; src[1] = 1'b1;
    wait_cyc(5);
    check("two_irq", 32'(irq), 32'd1);
    rd("two_claim1", 2'd2, 32'd2);
    check("two_irq_low", 32'(irq), 32'd0);
    wr(2'd2, 32'd2);
    check("two_irq_back", 32'(irq), 32'd1);
    rd("two_claim2", 2'd2, 32'd6);
    wr(2'd2, 32'd6);
    rd("two_claim3", 2'd2, 32'd0);
    rd("two_active", 2'd3, 32'h00);
    src[5] = 1'b0; src[1] = 1'b0;

    // Re-pend while active
    src[0] = 1'b1;
    wait_cyc(4);
    rd("rp_claim", 2'd2, 32'd1);
    src[0] = 1'b0;
    wait_cyc(3);
    src[0] = 1'b1;
    wait_cyc(4);
    rd("rp_pending", 2'd0, 32'h00);
    rd("rp_active", 2'd3, 32'h01);
    wr(2'd2, 32'd1);
    rd("rp_pending2", 2'd0, 32'h01);
    check("rp_irq", 32'(irq), 32'd1);
    rd("rp_claim2", 2'd2, 32'd1);
    wr(2'd2, 32'd1);
    rd("rp_pending3", 2'd0, 32'h00);
    src[0] = 1'b0;

    // Ignored completes and read-only writes
    src[4] = 1'b1;
    wait_cyc(4);
    rd("ig_claim", 2'd2, 32'd5);
    src[6] = 1'b1;
    wait_cyc(4);
    wr(2'd2, 32'd0);
    wr(2'd2, 32'd9);
    wr(2'd2, 32'd7);
    wr(2'd2, 32'd1);
    wr(2'd3, 32'hFF);
    wr(2'd0, 32'h00);
    rd("ig_pending", 2'd0, 32'h40);
    rd("ig_active", 2'd3, 32'h10);
    wr(2'd2, 32'd5);
    rd("ig_active2", 2'd3, 32'h00);
    rd("ig_claim7", 2'd2, 32'd7);
    wr(2'd2, 32'd7);
    src[4] = 1'b0; src[6] = 1'b0;

    // Event coinciding with claim of a pending source
    src[3] = 1'b1;
    wait_cyc(4);
    src[3] = 1'b0;
    wait_cyc(3);
    src[3] = 1'b1;
    wait_cyc(2);
    rd("ec_claim", 2'd2, 32'd4);
    rd("ec_active", 2'd3, 32'h08);
    rd("ec_pending", 2'd0, 32'h00);
    wr(2'd2, 32'd4);
    rd("ec_repend", 2'd0, 32'h08);

    // Event coinciding with complete of an active source
    rd("ex_claim", 2'd2, 32'd4);
    src[3] = 1'b0;
    wait_cyc(3);
    src[3] = 1'b1;
    wait_cyc(2);
    wr(2'd2, 32'd4);
    rd("ex_pending", 2'd0, 32'h08);
    rd("ex_active", 2'd3, 32'h00);
    rd("ex_claim2", 2'd2, 32'd4);
    wr(2'd2, 32'd4);
    src[3] = 1'b0;
    wait_cyc(3);

    // Disabled pending source
    wr(2'd1, 32'h00);
    src[3] = 1'b1;
    wait_cyc(5);
    check("dis_irq", 32'(irq), 32'd0);
    rd("dis_claim", 2'd2, 32'd0);
    rd("dis_pending", 2'd0, 32'h08);
    wr(2'd1, 32'h08);
    check("dis_irq_en", 32'(irq), 32'd1);

    // Back-to-back cyc: ack every other cycle, rdt zero between
    cyc = 1'b1; we = 1'b0; adr = 2'd1;
    @(posedge clk); @(negedge clk);
    check("b2b_ack1", 32'(ack), 32'd1);
    check("b2b_rdt1", rdt, 32'h08);
    @(posedge clk); @(negedge clk);
    check("b2b_ack2", 32'(ack), 32'd0);
    check("b2b_rdt2", rdt, 32'h00);
    @(posedge clk); @(negedge clk);
    check("b2b_ack3", 32'(ack), 32'd1);
    cyc = 1'b0;
    wait_cyc(1);

    // Reset in the middle of an access with PEND and ACT sources
    wr(2'd1, 32'h0A);
    src[1] = 1'b1;
    wait_cyc(5);
    rd("rs_claim", 2'd2, 32'd2);
    cyc = 1'b1; we = 1'b1; adr = 2'd1; dat = 32'hFF; rst_n = 1'b0;
    src[1] = 1'b0; src[3] = 1'b0; src[6] = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rs_ack", 32'(ack), 32'd0);
    check("rs_rdt", rdt, 32'd0);
    cyc = 1'b0; we = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    rd("rs_pending", 2'd0, 32'h00);
    check("rs_irq", 32'(irq), 32'd0);
    rd("rs_enable", 2'd1, 32'h00);
    rd("rs_active", 2'd3, 32'h00);

    // Source held high across reset release gives one event
    rd("hold_pending", 2'd0, 32'h40);
    wr(2'd1, 32'h40);
    rd("hold_claim", 2'd2, 32'd7);
    wr(2'd2, 32'd7);
    wait_cyc(4);
    rd("hold_pending2", 2'd0, 32'h00);
    rd("hold_active", 2'd3, 32'h00);
    src[6] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serv_irq_arb.md
SERV_IRQ_ARB -- requirements
Module: serv_irq_arb

Interface
REQ-001 SHALL have parameter N, default 8, number of interrupt sources (legal 1..31).
REQ-002 SHALL have i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have i_src  input  N  asynchronous level interrupt requests, rising edge significant.
REQ-005 SHALL have i_wb_adr  input  2  word address (bus bits 3:2).
REQ-006 SHALL have i_wb_dat  input  32  write data.
REQ-007 SHALL have i_wb_we  input  1  write enable.
REQ-008 SHALL have i_wb_cyc  input  1  bus cycle request.
REQ-009 SHALL have o_wb_rdt  output  32  read data, valid only while o_wb_ack high.
REQ-010 SHALL have o_wb_ack  output  1  single-cycle transfer acknowledge.
REQ-011 SHALL have o_irq  output  1  registered interrupt line to the core's i_mtip input.

Function
REQ-012 SHALL pass each i_src bit through a two-flop synchronizer plus one history flop; a rising edge on the synchronized value SHALL be an event, first visible in source state 3 edges after i_src is first sampled high.
REQ-013 SHALL keep a per-source FSM: IDLE, PEND, ACT, plus a per-source re-pend flag.
REQ-014 IDLE->PEND on event; PEND->ACT on claim selecting it; ACT->IDLE on matching complete, or ACT->PEND if re-pend set (re-pend cleared).
REQ-015 Event in PEND SHALL be merged (no effect); event in ACT SHALL set re-pend.
REQ-016 Register map: adr 0 PENDING (RO, bit i = source i in PEND); adr 1 ENABLE (RW, bits N-1:0); adr 2 CLAIM (read = claim, write = complete); adr 3 ACTIVE (RO, bit i = source i in ACT); unimplemented bits read 0, writes ignored; writes to RO registers ignored.
REQ-017 Claim read SHALL return id = i+1 for lowest index i with PEND and ENABLE set (0 if none) and move that source to ACT in the same cycle; id 0 changes no state.
REQ-018 Complete write SHALL take id from i_wb_dat[4:0]; id i+1 with source i in ACT completes it; id 0, id > N, or source not in ACT SHALL be ignored.
REQ-019 o_irq SHALL be registered: next value = OR(PEND & ENABLE) AND no source in ACT; o_irq therefore lags state by one cycle.
REQ-020 o_wb_ack SHALL be registered as i_wb_cyc & ~o_wb_ack; each access executes exactly once, on the cycle o_wb_ack is set; back-to-back cyc yields ack every other cycle.
REQ-021 o_wb_rdt SHALL be registered with the ack and SHALL be 0 when o_wb_ack is low.
REQ-022 Event and claim on the same source in the same cycle SHALL result in ACT with re-pend set.
REQ-023 Event and complete on the same ACT source in the same cycle SHALL result in PEND.
REQ-024 Clearing an ENABLE bit SHALL NOT alter source state; a disabled PEND source stays PEND, is not claimable and does not drive o_irq.
REQ-025 ENABLE write and claim SHALL never coincide (one access per ack); claim uses ENABLE as held before the cycle.

Reset
REQ-026 While i_rst_n is low at a clock edge: all FSMs IDLE, re-pend 0, ENABLE 0, synchronizer and history flops 0, o_irq 0, o_wb_ack 0, o_wb_rdt 0.
REQ-027 A bus access in flight at reset SHALL be dropped with no ack and no state change.
REQ-028 A source held high across reset release SHALL produce exactly one event (history resets to 0).

Verification
REQ-029 Raise i_src[2], ENABLE=0x04 -> PENDING=0x04 after 3 edges, o_irq=1 one cycle later; claim read returns 3, ACTIVE=0x04, o_irq drops next cycle.
REQ-030 Raise i_src[5] and i_src[1], ENABLE=0xFF -> first claim returns 2, complete 2 -> o_irq reasserts, second claim returns 6, third claim returns 0.
REQ-031 Claim source 0, pulse i_src[0] again while ACT -> PENDING=0x00; write complete 1 -> PENDING=0x01, o_irq=1.
REQ-032 Write complete with ids 0, 9 (N=8) and id of an IDLE source -> no change to PENDING/ACTIVE.
REQ-033 Source 3 PEND, ENABLE=0 -> o_irq=0, claim returns 0; set ENABLE=0x08 -> o_irq=1.
REQ-034 Assert i_rst_n=0 mid-access with sources PEND/ACT -> no ack, PENDING=ACTIVE=ENABLE=0, o_irq=0 after release.
